// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_pkg
// Purpose  : Shared types and the round-robin pick function for stream_mux_n.
// Revision : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    // Upper bound on channel count supported by rr_pick (index fits in 5 bits).
    localparam int unsigned c_MAX_CH    = 32;
    localparam int unsigned c_MAX_IDX_W = 5;

    typedef struct packed {
        logic                   found;
        logic [c_MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or above ptr, wrapping modulo n_ch.
    function automatic rr_pick_t rr_pick(
        input logic [c_MAX_CH-1:0]    valid,
        input logic [c_MAX_IDX_W-1:0] ptr,
        input int unsigned            n_ch
    );
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 0; k < c_MAX_CH; k++) begin
            if (!res.found && k < n_ch) begin
                cand = 32'(ptr) + k;
                if (cand >= n_ch) begin
                    cand = cand - n_ch;
                end
                if (valid[cand]) begin
                    res.found = 1'b1;
                    res.idx   = c_MAX_IDX_W'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/stream_mux_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr_arb
// Purpose  : Grant selection (lock / static / round-robin) and rr pointer.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr_arb
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  i_valid,
    input  mode_e            i_mode,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_lock,
    input  logic [SEL_W-1:0] i_lock_ch,
    input  logic             i_xfer,
    input  logic             i_advance,
    output logic             o_found,
    output logic [SEL_W-1:0] o_grant
);

    logic [SEL_W-1:0]       r_rr_ptr;
    logic [c_MAX_CH-1:0]    w_valid_ext;
    logic [c_MAX_IDX_W-1:0] w_ptr_ext;
    rr_pick_t               w_pick;

    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[N_CH-1:0]    = i_valid;
        w_ptr_ext                = '0;
        w_ptr_ext[SEL_W-1:0]     = r_rr_ptr;
        w_pick                   = rr_pick(w_valid_ext, w_ptr_ext, N_CH);
    end

    // A held packet lock overrides both selection modes.
    always_comb begin
        o_found = 1'b0;
        o_grant = '0;
        if (i_lock) begin
            o_found = 1'b1;
            o_grant = i_lock_ch;
        end else if (i_mode == MODE_STATIC) begin
            o_found = (32'(i_sel) < N_CH);
            o_grant = i_sel;
        end else begin
            o_found = w_pick.found;
            o_grant = SEL_W'(w_pick.idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (i_xfer && i_advance) begin
            r_rr_ptr <= (o_grant == SEL_W'(N_CH - 1)) ? '0 : o_grant + SEL_W'(1);
        end
    end

endmodule : stream_mux_rr_arb
`default_nettype wire

// File: rtl/stream_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_n
// Purpose  : N:1 registered valid/ready stream mux, static or round-robin.
//            Define STREAM_MUX_LAST_EN for packet-locked arbitration (last ports).
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_CH*DATA_W-1:0] in_data_i,
    input  logic [N_CH-1:0]        in_valid_i,
    output logic [N_CH-1:0]        in_ready_o,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic                   mode_i,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [SEL_W-1:0]       out_chan_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
`ifdef STREAM_MUX_LAST_EN
    ,
    input  logic [N_CH-1:0]        in_last_i,
    output logic                   out_last_o
`endif
);

    mode_e             w_mode;
    logic              w_free;
    logic              w_found;
    logic              w_xfer;
    logic              w_cur_last;
    logic              w_lock;
    logic              w_advance;
    logic [SEL_W-1:0]  w_grant;
    logic [SEL_W-1:0]  w_lock_ch;
    logic [N_CH-1:0]   w_ready;

    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_chan;
    logic              r_out_valid;

    assign w_mode = mode_e'(mode_i);
    assign w_free = !r_out_valid || out_ready_i;

    stream_mux_rr_arb #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_valid   (in_valid_i),
        .i_mode    (w_mode),
        .i_sel     (sel_i),
        .i_lock    (w_lock),
        .i_lock_ch (w_lock_ch),
        .i_xfer    (w_xfer),
        .i_advance (w_advance),
        .o_found   (w_found),
        .o_grant   (w_grant)
    );

    // Ready is forced low during reset since the cleared output looks "free".
    always_comb begin
        w_ready = '0;
        if (!rst_i && w_free && w_found && in_valid_i[w_grant]) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_xfer     = |w_ready;
    assign in_ready_o = w_ready;

`ifdef STREAM_MUX_LAST_EN
    logic             r_lock;
    logic [SEL_W-1:0] r_lock_ch;
    logic             r_out_last;

    assign w_cur_last = in_last_i[w_grant];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock     <= 1'b0;
            r_lock_ch  <= '0;
            r_out_last <= 1'b0;
        end else if (w_xfer) begin
            r_lock     <= !w_cur_last;
            r_lock_ch  <= w_grant;
            r_out_last <= w_cur_last;
        end
    end

    assign w_lock     = r_lock;
    assign w_lock_ch  = r_lock_ch;
    assign out_last_o = r_out_last;
`else
    assign w_cur_last = 1'b1;
    assign w_lock     = 1'b0;
    assign w_lock_ch  = '0;
`endif

    // Round-robin pointer moves only at packet boundaries in RR mode.
    assign w_advance = (w_mode == MODE_RR) && w_cur_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= in_data_i[int'(w_grant)*DATA_W +: DATA_W];
            r_out_chan  <= w_grant;
            r_out_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data_o  = r_out_data;
    assign out_chan_o  = r_out_chan;
    assign out_valid_o = r_out_valid;

endmodule : stream_mux_n
`default_nettype wire

// File: tb/tb_stream_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_n
// Purpose  : Directed stimulus with a queue scoreboard for stream_mux_n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_n;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b0;
    logic [N_CH*DATA_W-1:0] in_data_i = '0;
    logic [N_CH-1:0]        in_valid_i = '0;
    logic [N_CH-1:0]        in_ready_o;
    logic [1:0]             sel_i = '0;
    logic                   mode_i = 1'b0;
    logic [DATA_W-1:0]      out_data_o;
    logic [1:0]             out_chan_o;
    logic                   out_valid_o;
    logic                   out_ready_i = 1'b1;
`ifdef STREAM_MUX_LAST_EN
    logic [N_CH-1:0]        in_last_i = '1;
    logic                   out_last_o;
`endif

    stream_mux_n #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sel_i       (sel_i),
        .mode_i      (mode_i),
        .out_data_o  (out_data_o),
        .out_chan_o  (out_chan_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
`ifdef STREAM_MUX_LAST_EN
        ,
        .in_last_i   (in_last_i),
        .out_last_o  (out_last_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] chan;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t m_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Output side: one comparison per word actually consumed downstream.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got chan %0d data %0h, expected none", out_chan_o, out_data_o);
            end else begin
                m_exp = sb.pop_front();
                check("out_data", 32'(out_data_o), 32'(m_exp.data));
                check("out_chan", 32'(out_chan_o), 32'(m_exp.chan));
`ifdef STREAM_MUX_LAST_EN
                check("out_last", 32'(out_last_o), 32'(m_exp.last));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int c = 0; c < N_CH; c++) in_data_i[c*DATA_W +: DATA_W] = base + 8'(c);
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] ch, input logic l);
        exp_t e;
        e.data = d;
        e.chan = ch;
        e.last = l;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, check ready, record the expected word.
    task automatic xfer(input logic [3:0] v, input logic m, input logic [1:0] s,
                        input logic [7:0] base, input logic [1:0] ch, input logic l);
        in_valid_i = v;
        mode_i     = m;
        sel_i      = s;
        set_data(base);
        #1;
        check("in_ready", 32'(in_ready_o), 32'(4'b0001 << ch));
        push(base + 8'(ch), ch, l);
        step();
    endtask

    initial begin
        #1 rst_i = 1'b1;
        in_valid_i = 4'b1111;
        #1;
        check("rst_in_ready", 32'(in_ready_o), 32'h0);
        check("rst_out_valid", 32'(out_valid_o), 32'h0);
        step();
        check("rst_out_data", 32'(out_data_o), 32'h0);
        check("rst_out_chan", 32'(out_chan_o), 32'h0);
        in_valid_i = '0;
        rst_i      = 1'b0;

        // Static select of ch2
        in_valid_i = 4'b1111;
        mode_i     = 1'b0;
        sel_i      = 2'd2;
        set_data(8'h30);
        in_data_i[2*DATA_W +: DATA_W] = 8'hA5;
        #1;
        check("static_ready", 32'(in_ready_o), 32'h4);
        push(8'hA5, 2'd2, 1'b1);
        step();
        in_valid_i = '0;
        step();

        // RR fairness, one word per cycle
        for (int i = 0; i < 8; i++) xfer(4'b1111, 1'b1, 2'd0, 8'(i << 4), 2'(i % 4), 1'b1);

        // RR skip and wrap
        xfer(4'b0100, 1'b1, 2'd0, 8'h80, 2'd2, 1'b1);
        xfer(4'b0011, 1'b1, 2'd0, 8'h90, 2'd0, 1'b1);
        xfer(4'b0011, 1'b1, 2'd0, 8'hA0, 2'd1, 1'b1);
        xfer(4'b1000, 1'b1, 2'd0, 8'hB0, 2'd3, 1'b1);
        xfer(4'b1111, 1'b1, 2'd0, 8'hC0, 2'd0, 1'b1);

        // Backpressure: C0 held for 3 cycles
        out_ready_i = 1'b0;
        in_valid_i  = 4'b0010;
        set_data(8'hD0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(in_ready_o), 32'h0);
            check("stall_data", 32'(out_data_o), 32'hC0);
            check("stall_valid", 32'(out_valid_o), 32'h1);
            step();
        end
        out_ready_i = 1'b1;
        xfer(4'b0010, 1'b1, 2'd0, 8'hD0, 2'd1, 1'b1);
        in_valid_i = '0;
        step();
        #1;
        check("drain_valid", 32'(out_valid_o), 32'h0);
        check("drain_data_hold", 32'(out_data_o), 32'hD1);
        check("drain_chan_hold", 32'(out_chan_o), 32'h1);
        step();

        // Static transfer leaves rr_ptr (2) untouched
        xfer(4'b1111, 1'b0, 2'd3, 8'hE0, 2'd3, 1'b1);
        xfer(4'b1111, 1'b1, 2'd0, 8'hF0, 2'd2, 1'b1);

        // Reset mid-stream drops the held word
        out_ready_i = 1'b0;
        in_valid_i  = '0;
        #1;
        check("pre_rst_valid", 32'(out_valid_o), 32'h1);
        rst_i      = 1'b1;
        in_valid_i = 4'b1111;
        #1;
        check("midrst_out_valid", 32'(out_valid_o), 32'h0);
        check("midrst_in_ready", 32'(in_ready_o), 32'h0);
        void'(sb.pop_back());
        step();
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        xfer(4'b1111, 1'b1, 2'd0, 8'h10, 2'd0, 1'b1);
        in_valid_i = '0;

`ifdef STREAM_MUX_LAST_EN
        // RR packet on ch2 (ptr moved to 2 first), then RR resumes after it
        xfer(4'b0010, 1'b1, 2'd0, 8'h20, 2'd1, 1'b1);
        in_last_i = 4'b1011;
        xfer(4'b0111, 1'b1, 2'd0, 8'h30, 2'd2, 1'b0);
        xfer(4'b0111, 1'b1, 2'd0, 8'h40, 2'd2, 1'b0);
        in_last_i = 4'b1111;
        xfer(4'b0111, 1'b1, 2'd0, 8'h50, 2'd2, 1'b1);
        xfer(4'b1011, 1'b1, 2'd0, 8'h60, 2'd3, 1'b1);
        xfer(4'b0011, 1'b1, 2'd0, 8'h70, 2'd0, 1'b1);
        // Static packet: sel change mid-packet is ignored until last
        in_last_i = 4'b1011;
        xfer(4'b0111, 1'b0, 2'd2, 8'h80, 2'd2, 1'b0);
        xfer(4'b0111, 1'b0, 2'd1, 8'h90, 2'd2, 1'b0);
        in_last_i = 4'b1111;
        xfer(4'b0111, 1'b0, 2'd1, 8'hA0, 2'd2, 1'b1);
        xfer(4'b0111, 1'b0, 2'd1, 8'hB0, 2'd1, 1'b1);
        in_valid_i = '0;
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stream_mux_n
`default_nettype wire
